// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// spi_controller - SPI mode-0 initiator, LSB first: TX phase, turnaround, RX.
// Revision: 1.0
// ============================================================================
module spi_controller #(
  parameter int LENGTH_SEND     = 8,
  parameter int LENGTH_RECIEVED = 8,
  parameter int TURNAROUND      = 1,
  parameter int CLK_DIV         = 4,
  parameter int LENGTH_COUNT    = 5
) (
  input  logic                       clk,
  input  logic                       rst_internal,
  input  logic                       start,
  input  logic [LENGTH_SEND-1:0]     data_in,
  output logic                       busy,
  output logic                       done,
  output logic [LENGTH_RECIEVED-1:0] data_out,
  output logic                       SCK,
  output logic                       CS,
  output logic                       COPI,
  input  logic                       CIPO
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LENGTH_COUNT-1:0] CNT_SEND     = LENGTH_COUNT'(LENGTH_SEND);
  localparam logic [LENGTH_COUNT-1:0] CNT_RX_START = LENGTH_COUNT'(LENGTH_SEND + TURNAROUND);
  localparam logic [LENGTH_COUNT-1:0] CNT_TOTAL    =
    LENGTH_COUNT'(LENGTH_SEND + TURNAROUND + LENGTH_RECIEVED);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_TRANSFER = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [DIV_W-1:0]           div_cnt_q, div_cnt_d;
  logic [LENGTH_COUNT-1:0]    edge_cnt_q, edge_cnt_d;
  logic [LENGTH_SEND-1:0]     tx_shift_q, tx_shift_d;
  logic [LENGTH_RECIEVED-1:0] rx_shift_q, rx_shift_d;
  logic [LENGTH_RECIEVED-1:0] data_out_q, data_out_d;
  logic                       sck_q, sck_d;
  logic                       cs_q, cs_d;
  logic                       copi_q, copi_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       gap_half_q, gap_half_d;

  logic                       w_event;
  logic [LENGTH_SEND-1:0]     w_tx_next;
  logic [LENGTH_RECIEVED:0]   w_rx_cat;

  assign w_event   = (state_q != S_IDLE) && (div_cnt_q == DIV_LAST);
  // Shifting before picking bit 0 keeps this valid even for a 1-bit TX word.
  assign w_tx_next = tx_shift_q >> 1;
  assign w_rx_cat  = {CIPO, rx_shift_q};

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    data_out_d = data_out_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    copi_d     = copi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    gap_half_d = gap_half_q;
    div_cnt_d  = (state_q == S_IDLE || w_event) ? '0 : div_cnt_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        sck_d = 1'b0;
        cs_d  = 1'b1;
        if (start) begin
          tx_shift_d = data_in;
          cs_d       = 1'b0;
          copi_d     = data_in[0];
          busy_d     = 1'b1;
          edge_cnt_d = '0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_event) begin
          sck_d      = 1'b1;
          edge_cnt_d = LENGTH_COUNT'(1);
          state_d    = S_TRANSFER;
        end
      end
      S_TRANSFER: begin
        if (w_event) begin
          if (!sck_q) begin
            sck_d      = 1'b1;
            edge_cnt_d = edge_cnt_q + LENGTH_COUNT'(1);
            // Capture on rising edges LENGTH_SEND+TURNAROUND+1 .. TOTAL.
            if (edge_cnt_q >= CNT_RX_START) begin
              rx_shift_d = w_rx_cat[LENGTH_RECIEVED:1];
            end
          end else begin
            sck_d      = 1'b0;
            tx_shift_d = w_tx_next;
            copi_d     = (edge_cnt_q < CNT_SEND) ? w_tx_next[0] : 1'b0;
            if (edge_cnt_q == CNT_TOTAL) begin
              state_d = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (w_event) begin
          cs_d       = 1'b1;
          data_out_d = rx_shift_q;
          done_d     = 1'b1;
          gap_half_d = 1'b0;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        // Two divider periods of CS high so the peripheral can reset its state.
        if (w_event) begin
          if (gap_half_q) begin
            gap_half_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
          end else begin
            gap_half_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        sck_d   = 1'b0;
        cs_d    = 1'b1;
        copi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_internal) begin
    if (!rst_internal) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      data_out_q <= '0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      copi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gap_half_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      data_out_q <= data_out_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      copi_q     <= copi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gap_half_q <= gap_half_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;
  assign SCK      = sck_q;
  assign CS       = cs_q;
  assign COPI     = copi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// tb_spi_controller - directed bench with a mode-0 peripheral model.
// Revision: 1.0
// ============================================================================
module tb_spi_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, start1;
  logic [7:0] data_in, data_in1;
  logic       CIPO, CIPO1;
  logic       busy, done, SCK, CS, COPI;
  logic       busy1, done1, SCK1, CS1, COPI1;
  logic [7:0] data_out, data_out1;

  spi_controller #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_internal(rst_n), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .data_out(data_out),
    .SCK(SCK), .CS(CS), .COPI(COPI), .CIPO(CIPO)
  );

  spi_controller #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_internal(rst_n), .start(start1), .data_in(data_in1),
    .busy(busy1), .done(done1), .data_out(data_out1),
    .SCK(SCK1), .CS(CS1), .COPI(COPI1), .CIPO(CIPO1)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc, done_cyc, lat, gap, pulses_before;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model for the CLK_DIV=4 instance.
  logic [7:0] data_send   = 8'h00;
  logic [7:0] copi_reg    = 8'h00;
  int         pr_cnt      = 0;
  int         sck_cs_viol = 0;
  int         done_pulses = 0;

  always @(negedge CS) begin
    pr_cnt   = 0;
    copi_reg = 8'h00;
    CIPO     = 1'b0;
  end
  always @(posedge SCK) begin
    if (CS) sck_cs_viol++;
    if (pr_cnt < 8) copi_reg[pr_cnt] = COPI;
    pr_cnt++;
  end
  always @(negedge SCK) begin
    if (!CS && pr_cnt >= 9 && pr_cnt < 17) CIPO = data_send[pr_cnt-9];
  end
  always @(negedge clk) if (done === 1'b1) done_pulses++;

  // Capture for the CLK_DIV=1 instance.
  logic [7:0] copi1_reg = 8'h00;
  int         cnt1      = 0;
  time        sck1_prev = 0;
  time        sck1_period = 0;
  always @(negedge CS1) begin
    cnt1      = 0;
    copi1_reg = 8'h00;
  end
  always @(posedge SCK1) begin
    if (cnt1 < 8) copi1_reg[cnt1] = COPI1;
    cnt1++;
    sck1_period = $time - sck1_prev;
    sck1_prev   = $time;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept0(input logic [7:0] d);
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start   = 1'b0;
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_cs", {31'd0, CS}, 32'd0);
    chk("accept_copi", {31'd0, COPI}, {31'd0, d[0]});
  endtask

  task automatic wait_done0(input int bound, output int latency);
    latency = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) break;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    if (done === 1'b1) latency = cyc - acc_cyc;
    done_cyc = cyc;
  endtask

  task automatic wait_idle0(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (busy === 1'b0) break;
      @(posedge clk); #1;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_rise5(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (pr_cnt >= 5) break;
      @(negedge clk);
    end
    chk("rise5_reached", {31'd0, pr_cnt == 5}, 32'd1);
  endtask

  task automatic frame1(input logic [7:0] d, input logic cipo_v);
    CIPO1 = cipo_v;
    @(negedge clk);
    data_in1 = d;
    start1   = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start1  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) break;
    end
    chk("div1_done_seen", {31'd0, done1}, 32'd1);
    chk("div1_latency", cyc - acc_cyc, 32'd35);
    chk("div1_data_out", {24'd0, data_out1}, {24'd0, {8{cipo_v}}});
    chk("div1_copi", {24'd0, copi1_reg}, {24'd0, d});
    chk("div1_sck_period", 32'(sck1_period), 32'd20);
    repeat (4) @(posedge clk);
    #1 chk("div1_idle", {31'd0, busy1}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    data_in = 8'h00; data_in1 = 8'h00; CIPO = 1'b0; CIPO1 = 1'b0;

    // Reset held with start toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start  = ~start;
      start1 = ~start1;
    end
    #1;
    chk("rst_sck", {31'd0, SCK}, 32'd0);
    chk("rst_cs", {31'd0, CS}, 32'd1);
    chk("rst_copi", {31'd0, COPI}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_cs1", {31'd0, CS1}, 32'd1);
    @(negedge clk);
    start = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame.
    data_send = 8'hA5;
    accept0(8'h3C);
    wait_done0(400, lat);
    chk("single_latency", lat, 32'd140);
    chk("single_data_out", {24'd0, data_out}, 32'h0000_00A5);
    chk("single_cs_in_done", {31'd0, CS}, 32'd1);
    chk("single_copi_reg", {24'd0, copi_reg}, 32'h0000_003C);
    chk("single_rise_count", pr_cnt, 32'd17);
    @(posedge clk); #1;
    chk("single_done_one_cycle", {31'd0, done}, 32'd0);
    wait_idle0(40);
    chk("single_idle_delay", cyc - done_cyc, 32'd8);

    // Start while busy is ignored.
    data_send     = 8'h5A;
    pulses_before = done_pulses;
    accept0(8'h3C);
    wait_rise5(400);
    data_in = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done0(400, lat);
    chk("busy_data_out", {24'd0, data_out}, 32'h0000_005A);
    wait_idle0(40);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_copi_reg", {24'd0, copi_reg}, 32'h0000_003C);
    chk("busy_one_done", done_pulses - pulses_before, 32'd1);
    chk("busy_stays_idle", {31'd0, busy}, 32'd0);

    // Back-to-back with start held high.
    data_send = 8'h0F;
    @(negedge clk);
    data_in = 8'h01;
    start   = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    chk("b2b_first_accept", {31'd0, busy}, 32'd1);
    @(negedge clk);
    data_in = 8'h80;
    wait_done0(400, lat);
    chk("b2b_first_data_out", {24'd0, data_out}, 32'h0000_000F);
    chk("b2b_first_copi", {24'd0, copi_reg}, 32'h0000_0001);
    data_send = 8'hF0;
    gap = 0;
    for (int i = 0; i < 40; i++) begin
      if (CS !== 1'b1) break;
      gap++;
      @(posedge clk); #1;
    end
    acc_cyc = cyc;
    start   = 1'b0;
    chk("b2b_second_accept", {31'd0, CS}, 32'd0);
    chk("b2b_gap_ge8", {31'd0, gap >= 8}, 32'd1);
    wait_done0(400, lat);
    chk("b2b_second_latency", lat, 32'd140);
    chk("b2b_second_data_out", {24'd0, data_out}, 32'h0000_00F0);
    chk("b2b_second_copi", {24'd0, copi_reg}, 32'h0000_0080);
    wait_idle0(40);

    // Mid-frame asynchronous reset.
    data_send     = 8'hEE;
    pulses_before = done_pulses;
    accept0(8'h77);
    wait_rise5(400);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", {31'd0, CS}, 32'd1);
    chk("mid_rst_sck", {31'd0, SCK}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_copi", {31'd0, COPI}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("mid_rst_no_done", done_pulses - pulses_before, 32'd0);
    chk("mid_rst_data_out", {24'd0, data_out}, 32'd0);
    data_send = 8'hC3;
    accept0(8'h5A);
    wait_done0(400, lat);
    chk("post_rst_latency", lat, 32'd140);
    chk("post_rst_data_out", {24'd0, data_out}, 32'h0000_00C3);
    chk("post_rst_copi", {24'd0, copi_reg}, 32'h0000_005A);
    wait_idle0(40);

    // CLK_DIV=1 edge patterns.
    frame1(8'h00, 1'b0);
    frame1(8'hFF, 1'b1);

    chk("sck_while_cs_high", sck_cs_viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
